// File: rtl/array_count_engine.sv
// array_count_engine: multi-cycle scan of one heap array area against a key.
// Returns one of four results: a count of elements greater than the key, a count
// of elements less than the key, the index of the first element greater than the
// key, or the index of the first element equal to the key. The engine issues one
// heap read per cycle and compares each element in the cycle after its read.
module array_count_engine #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 4,
  parameter int NArrays            = 4,
  parameter int AddressWidth       = 12
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [MemoryElementWidth-1:0] array,
  input  logic [MemoryElementWidth-1:0] size,
  input  logic [MemoryElementWidth-1:0] key,
  output logic [AddressWidth-1:0]       memAddr,
  output logic                          memRead,
  input  logic [MemoryElementWidth-1:0] memData,
  output logic                          busy,
  output logic                          done,
  output logic [MemoryElementWidth-1:0] result,
  output logic                          error
);

  localparam int MEW = MemoryElementWidth;
  localparam int AW  = AddressWidth;

  localparam logic [MEW-1:0] AREA_LEN = MEW'(NArea);
  localparam logic [MEW-1:0] ARR_CNT  = MEW'(NArrays);
  localparam logic [MEW-1:0] ONE      = MEW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Scan modes; bit 1 set means "index of first match" rather than "count".
  typedef enum logic [1:0] {
    M_CNT_GT = 2'd0,
    M_CNT_LT = 2'd1,
    M_IDX_GT = 2'd2,
    M_IDX_EQ = 2'd3
  } mode_e;

  state_e         state_q, state_d;
  mode_e          mode_q, mode_d;
  logic [MEW-1:0] key_q, key_d;
  logic [AW-1:0]  base_q, base_d;
  logic [MEW-1:0] len_q, len_d;
  logic [MEW-1:0] i_q, i_d;            // index of the next read to issue
  logic [MEW-1:0] acc_q, acc_d;        // running count, or first-match index
  logic           found_q, found_d;    // a first match has been recorded
  logic           err_q, err_d;        // error of the scan in flight
  logic           rd_vld_q, rd_vld_d;  // memData carries an element this cycle
  logic [MEW-1:0] cmp_idx_q, cmp_idx_d;// index of the element on memData
  logic [MEW-1:0] result_q, result_d;
  logic           error_q, error_d;

  // Combinational view of the element on memData and the accumulator after it.
  logic           match;
  logic [MEW-1:0] acc_upd;
  logic           found_upd;
  logic [MEW-1:0] final_res;

  // Acceptance-time operand decoding, straight from the request inputs.
  logic           bad_array;
  logic           bad_size;
  logic [MEW-1:0] len_clip;

  // Compare the element returned by last cycle's read and fold it into the accumulator.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    match     = 1'b0;
    acc_upd   = acc_q;
    found_upd = found_q;
    unique case (mode_q)
      M_CNT_GT, M_IDX_GT: match = (memData > key_q);
      M_CNT_LT:           match = (memData < key_q);
      M_IDX_EQ:           match = (memData == key_q);
      default:            match = 1'b0;
    endcase
    if (rd_vld_q && match) begin
      if (!mode_q[1]) begin
        // Count never exceeds NArea, so this cannot wrap at MEW bits.
        acc_upd = acc_q + ONE;
      end else if (!found_q) begin
        acc_upd   = cmp_idx_q;
        found_upd = 1'b1;
      end
    end
    // Index modes report the scan length when nothing matched.
    final_res = (mode_q[1] && !found_upd) ? len_q : acc_upd;
  end

  // Decode the request operands seen while idle.
  always_comb begin
    bad_array = (array >= ARR_CNT);
    bad_size  = (size > AREA_LEN);
    len_clip  = bad_size ? AREA_LEN : size;
  end

  // Next-state and output logic for the scan sequencer.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    key_d     = key_q;
    base_d    = base_q;
    len_d     = len_q;
    i_d       = i_q;
    acc_d     = acc_q;
    found_d   = found_q;
    err_d     = err_q;
    rd_vld_d  = 1'b0;
    cmp_idx_d = i_q;
    result_d  = result_q;
    error_d   = error_q;
    memRead   = 1'b0;
    memAddr   = '0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          key_d   = key;
          base_d  = AW'(array * AREA_LEN);
          len_d   = len_clip;
          i_d     = '0;
          acc_d   = '0;
          found_d = 1'b0;
          err_d   = bad_array || bad_size;
          if (bad_array || (len_clip == '0)) begin
            // Nothing to read: the answer is known now and is always zero.
            result_d = '0;
            error_d  = bad_array || bad_size;
            state_d  = S_DONE;
          end else begin
            state_d = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        busy     = 1'b1;
        memRead  = 1'b1;
        memAddr  = base_q + AW'(i_q);
        rd_vld_d = 1'b1;
        acc_d    = acc_upd;
        found_d  = found_upd;
        i_d      = i_q + ONE;
        if (i_q == len_q - ONE) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // The last element arrives now; publish the result together with the error.
        busy     = 1'b1;
        acc_d    = acc_upd;
        found_d  = found_upd;
        result_d = final_res;
        error_d  = err_q;
        state_d  = S_DONE;
      end

      S_DONE: begin
        // start is deliberately ignored here; it is honoured again next cycle.
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    result = result_q;
    error  = error_q;
  end

  // State and datapath registers; reset abandons any scan in flight.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= M_CNT_GT;
      key_q     <= '0;
      base_q    <= '0;
      len_q     <= '0;
      i_q       <= '0;
      acc_q     <= '0;
      found_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      cmp_idx_q <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      key_q     <= key_d;
      base_q    <= base_d;
      len_q     <= len_d;
      i_q       <= i_d;
      acc_q     <= acc_d;
      found_q   <= found_d;
      err_q     <= err_d;
      rd_vld_q  <= rd_vld_d;
      cmp_idx_q <= cmp_idx_d;
      result_q  <= result_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_array_count_engine.sv
// Directed bench for array_count_engine with a one-cycle-latency heap model.
module tb_array_count_engine;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [11:0] array;
  logic [11:0] size;
  logic [11:0] key;
  logic [11:0] memAddr;
  logic        memRead;
  logic [11:0] memData;
  logic        busy;
  logic        done;
  logic [11:0] result;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [11:0] heap [0:15];
  int          rd_cnt = 0;
  logic [11:0] addr_log [0:255];

  // Values captured by run_op.
  int   lat;
  int   rd_start;
  logic busy_first;
  logic done_after;
  int   done_cnt;

  array_count_engine #(
    .MemoryElementWidth(12),
    .NArea(4),
    .NArrays(4),
    .AddressWidth(12)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .array  (array),
    .size   (size),
    .key    (key),
    .memAddr(memAddr),
    .memRead(memRead),
    .memData(memData),
    .busy   (busy),
    .done   (done),
    .result (result),
    .error  (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Heap read port: data appears one cycle after the strobe; every read is logged.
  always @(posedge clock) begin
    if (memRead) begin
      memData <= heap[memAddr[3:0]];
      addr_log[rd_cnt[7:0]] = memAddr;
      rd_cnt = rd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs after acceptance, optionally poke
  // start mid-scan and during the done cycle, and wait (bounded) for done.
  task automatic run_op(input logic [1:0] md, input logic [11:0] arr,
                        input logic [11:0] sz, input logic [11:0] k, input bit poke);
    bit seen;
    @(negedge clock);
    mode = md; array = arr; size = sz; key = k; start = 1'b1;
    rd_start = rd_cnt;
    @(posedge clock);
    #1;
    start = 1'b0; key = ~k; size = 12'd0; array = 12'd0; mode = ~md;
    lat = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clock);
      if (lat == 0) busy_first = busy;
      if (poke && lat < 2) begin
        start = 1'b1; key = 12'd0; mode = 2'd1; array = 12'd1; size = 12'd1;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1;
      else lat++;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    start = poke ? 1'b1 : 1'b0;  // held only through the done cycle
    @(negedge clock);
    start = 1'b0;
    done_after = done;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; array = 12'd0; size = 12'd0; key = 12'd0;
    memData = 12'd0;
    for (int i = 0; i < 16; i++) heap[i] = 12'd0;
    heap[0] = 12'd10; heap[1] = 12'd20; heap[2] = 12'd30; heap[3] = 12'd99;
    for (int i = 4; i < 8; i++) heap[i] = 12'd50;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_memread", 32'(memRead), 32'd0);
    check("rst_memaddr", 32'(memAddr), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;

    // Count greater: 20,30 > 15.
    run_op(2'd0, 12'd0, 12'd3, 12'd15, 1'b0);
    check("gt_latency", 32'(lat), 32'd4);
    check("gt_busy", 32'(busy_first), 32'd1);
    check("gt_result", 32'(result), 32'd2);
    check("gt_error", 32'(error), 32'd0);
    check("gt_reads", 32'(rd_cnt - rd_start), 32'd3);
    check("gt_addr0", 32'(addr_log[rd_start[7:0]]), 32'd0);
    check("gt_addr2", 32'(addr_log[8'(rd_start + 2)]), 32'd2);
    check("gt_done_pulse", 32'(done_after), 32'd0);

    // Count less: only 10 < 15.
    run_op(2'd1, 12'd0, 12'd3, 12'd15, 1'b0);
    check("lt_result", 32'(result), 32'd1);

    // First index greater: 20 at index 1.
    run_op(2'd2, 12'd0, 12'd3, 12'd15, 1'b0);
    check("idxgt_result", 32'(result), 32'd1);

    // First index equal: 20 at index 1.
    run_op(2'd3, 12'd0, 12'd3, 12'd20, 1'b0);
    check("idxeq_result", 32'(result), 32'd1);
    check("idxeq_latency", 32'(lat), 32'd4);

    // Zero-length array.
    run_op(2'd2, 12'd0, 12'd0, 12'd15, 1'b0);
    check("len0_latency", 32'(lat), 32'd0);
    check("len0_busy", 32'(busy_first), 32'd0);
    check("len0_result", 32'(result), 32'd0);
    check("len0_error", 32'(error), 32'd0);
    check("len0_reads", 32'(rd_cnt - rd_start), 32'd0);

    // Oversize request clipped to NArea on array 1 (base 4), error flagged.
    run_op(2'd0, 12'd1, 12'd6, 12'd0, 1'b0);
    check("big_result", 32'(result), 32'd4);
    check("big_error", 32'(error), 32'd1);
    check("big_latency", 32'(lat), 32'd5);
    check("big_reads", 32'(rd_cnt - rd_start), 32'd4);
    check("big_addr0", 32'(addr_log[rd_start[7:0]]), 32'd4);
    check("big_addr3", 32'(addr_log[8'(rd_start + 3)]), 32'd7);

    // Array number out of range.
    run_op(2'd0, 12'd5, 12'd3, 12'd0, 1'b0);
    check("badarr_latency", 32'(lat), 32'd0);
    check("badarr_result", 32'(result), 32'd0);
    check("badarr_error", 32'(error), 32'd1);
    check("badarr_reads", 32'(rd_cnt - rd_start), 32'd0);

    // start pulsed during the scan and in the done cycle must be ignored.
    run_op(2'd0, 12'd0, 12'd3, 12'd15, 1'b1);
    check("poke_result", 32'(result), 32'd2);
    check("poke_latency", 32'(lat), 32'd4);
    check("poke_error", 32'(error), 32'd0);
    done_cnt = 0;
    rd_start = rd_cnt;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (done || busy) done_cnt++;
    end
    check("poke_no_restart", 32'(done_cnt), 32'd0);
    check("poke_no_reads", 32'(rd_cnt - rd_start), 32'd0);
    check("poke_result_held", 32'(result), 32'd2);

    // No match in first-index-equal mode returns the length.
    run_op(2'd3, 12'd0, 12'd3, 12'd40, 1'b0);
    check("nomatch_result", 32'(result), 32'd3);

    // Reset in the middle of a scan.
    @(negedge clock);
    mode = 2'd0; array = 12'd0; size = 12'd3; key = 12'd15; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_memread", 32'(memRead), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_memaddr", 32'(memAddr), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (done) done_cnt++;
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);

    run_op(2'd0, 12'd0, 12'd3, 12'd15, 1'b0);
    check("post_rst_result", 32'(result), 32'd2);
    check("post_rst_latency", 32'(lat), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
